// File: rtl/hyperbus_mem_responder.sv
// HyperBus device-side responder: 3-beat CA decode, latency, memory/register read, masked write.
// Optional build macro HBRESP_FIXED_2X_LAT_EN: latency is always doubled and rwds_out is high during CA.
module hyperbus_mem_responder #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned LATENCY    = 6,
    parameter int unsigned WRAP_WORDS = 16,
    parameter logic [15:0] ID0_VAL    = 16'h0C81,
    parameter logic [15:0] ID1_VAL    = 16'h0001,
    parameter logic [15:0] CR0_RST    = 16'h8F1F,
    parameter logic [15:0] CR1_RST    = 16'hFFC1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        csn_i,
    input  logic        ck_en_i,
    input  logic [15:0] dq_in_i,
    output logic [15:0] dq_out_o,
    output logic        dq_oe_o,
    input  logic        rwds_in_i,
    output logic        rwds_out_o,
    output logic        rwds_oe_o,
    output logic        busy_o
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef HBRESP_FIXED_2X_LAT_EN
    localparam int unsigned LAT_BEATS = 2 * LATENCY;
    localparam logic        CA_RWDS   = 1'b1;
`else
    localparam int unsigned LAT_BEATS = LATENCY;
    localparam logic        CA_RWDS   = 1'b0;
`endif
    localparam logic [ADDR_W-1:0] WRAP_MASK = ADDR_W'(WRAP_WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [4:0]        LAT_LOAD  = 5'(LAT_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CA, S_LAT, S_REGWR, S_RDATA, S_WDATA, S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic                ca_second_q, ca_second_d;
    logic [31:0]         ca_hi_q, ca_hi_d;
    logic [4:0]          lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                is_read_q, is_read_d;
    logic                is_reg_q, is_reg_d;
    logic                linear_q, linear_d;
    logic [1:0]          reg_sel_q, reg_sel_d;
    logic [15:0]         cr0_q, cr0_d;
    logic [15:0]         cr1_q, cr1_d;
    logic [15:0]         dq_out_q, dq_out_d;
    logic                dq_oe_q, dq_oe_d;
    logic                rwds_out_q, rwds_out_d;
    logic                rwds_oe_q, rwds_oe_d;
    logic                armed_q, armed_d;

    logic [15:0]         mem_q [DEPTH];
    logic                mem_we;
    logic                load_rd;
    logic [47:0]         ca_full;
    logic [ADDR_W-1:0]   ca_addr;
    logic [ADDR_W-1:0]   addr_inc;
    logic [ADDR_W-1:0]   addr_next;
    logic [15:0]         reg_val;
    logic [15:0]         rd_val;
    logic                unused_ca;

    // Third CA beat is decoded straight off the pins together with the two stored beats.
    assign ca_full   = {ca_hi_q, dq_in_i};
    assign ca_addr   = {ca_full[ADDR_W+12:16], ca_full[2:0]};
    assign unused_ca = ^ca_full;

    assign addr_inc  = addr_q + ADDR_ONE;
    assign addr_next = linear_q ? addr_inc
                                : ((addr_q & ~WRAP_MASK) | (addr_inc & WRAP_MASK));

    always_comb begin
        reg_val = ID0_VAL;
        case (reg_sel_q)
            2'b00:   reg_val = ID0_VAL;
            2'b01:   reg_val = ID1_VAL;
            2'b10:   reg_val = cr0_q;
            default: reg_val = cr1_q;
        endcase
    end

    assign rd_val = is_reg_q ? reg_val : mem_q[addr_q];

    always_comb begin
        state_d     = state_q;
        ca_second_d = ca_second_q;
        ca_hi_d     = ca_hi_q;
        lat_cnt_d   = lat_cnt_q;
        addr_d      = addr_q;
        is_read_d   = is_read_q;
        is_reg_d    = is_reg_q;
        linear_d    = linear_q;
        reg_sel_d   = reg_sel_q;
        cr0_d       = cr0_q;
        cr1_d       = cr1_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = dq_oe_q;
        rwds_out_d  = rwds_out_q;
        rwds_oe_d   = rwds_oe_q;
        armed_d     = armed_q;
        mem_we      = 1'b0;
        load_rd     = 1'b0;

        if (csn_i) begin
            state_d    = S_IDLE;
            armed_d    = 1'b1;
            dq_out_d   = '0;
            dq_oe_d    = 1'b0;
            rwds_out_d = 1'b0;
            rwds_oe_d  = 1'b0;
        end else if (ck_en_i) begin
            case (state_q)
                S_IDLE: begin
                    // Only a fresh csn falling edge starts a transaction.
                    if (armed_q) begin
                        armed_d       = 1'b0;
                        ca_hi_d[31:16] = dq_in_i;
                        ca_second_d   = 1'b0;
                        state_d       = S_CA;
                        rwds_oe_d     = 1'b1;
                        rwds_out_d    = CA_RWDS;
                    end
                end
                S_CA: begin
                    if (!ca_second_q) begin
                        ca_hi_d[15:0] = dq_in_i;
                        ca_second_d   = 1'b1;
                    end else begin
                        rwds_oe_d  = 1'b0;
                        rwds_out_d = 1'b0;
                        is_read_d  = ca_full[47];
                        is_reg_d   = ca_full[46];
                        linear_d   = ca_full[45];
                        reg_sel_d  = {ca_full[24], ca_full[0]};
                        addr_d     = ca_addr;
                        lat_cnt_d  = LAT_LOAD;
                        state_d    = (ca_full[46] && !ca_full[47]) ? S_REGWR : S_LAT;
                    end
                end
                S_LAT: begin
                    if (lat_cnt_q == '0) begin
                        if (is_read_q) begin
                            state_d = S_RDATA;
                            load_rd = 1'b1;
                        end else begin
                            state_d = S_WDATA;
                        end
                    end else begin
                        lat_cnt_d = lat_cnt_q - 5'd1;
                    end
                end
                S_RDATA: load_rd = 1'b1;
                S_WDATA: begin
                    mem_we = 1'b1;
                    addr_d = addr_next;
                end
                S_REGWR: begin
                    if (reg_sel_q == 2'b10) cr0_d = dq_in_i;
                    if (reg_sel_q == 2'b11) cr1_d = dq_in_i;
                    state_d = S_DONE;
                end
                default: ;
            endcase

            if (load_rd) begin
                dq_out_d   = rd_val;
                dq_oe_d    = 1'b1;
                rwds_oe_d  = 1'b1;
                rwds_out_d = 1'b1;
                if (!is_reg_q) addr_d = addr_next;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            ca_second_q <= 1'b0;
            ca_hi_q     <= '0;
            lat_cnt_q   <= '0;
            addr_q      <= '0;
            is_read_q   <= 1'b0;
            is_reg_q    <= 1'b0;
            linear_q    <= 1'b0;
            reg_sel_q   <= '0;
            cr0_q       <= CR0_RST;
            cr1_q       <= CR1_RST;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            rwds_out_q  <= 1'b0;
            rwds_oe_q   <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ca_second_q <= ca_second_d;
            ca_hi_q     <= ca_hi_d;
            lat_cnt_q   <= lat_cnt_d;
            addr_q      <= addr_d;
            is_read_q   <= is_read_d;
            is_reg_q    <= is_reg_d;
            linear_q    <= linear_d;
            reg_sel_q   <= reg_sel_d;
            cr0_q       <= cr0_d;
            cr1_q       <= cr1_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            rwds_out_q  <= rwds_out_d;
            rwds_oe_q   <= rwds_oe_d;
            armed_q     <= armed_d;
        end
    end

    // Low byte is always written; rwds_in high preserves the stored high byte.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[addr_q][7:0] <= dq_in_i[7:0];
            if (!rwds_in_i) mem_q[addr_q][15:8] <= dq_in_i[15:8];
        end
    end

    assign dq_out_o   = dq_out_q;
    assign dq_oe_o    = dq_oe_q;
    assign rwds_out_o = rwds_out_q;
    assign rwds_oe_o  = rwds_oe_q;
    assign busy_o     = (state_q != S_IDLE);

endmodule
